// File: rtl/axi_id_remap_pkg.sv
// AXI4 channel and port struct types shared by the ID remapper and its users.
// Slave side carries 4-bit IDs, master side 2-bit IDs.
package axi_id_remap_pkg;

  localparam int unsigned AxiAddrWidth   = 32;
  localparam int unsigned AxiDataWidth   = 32;
  localparam int unsigned AxiSlvIdWidth  = 4;
  localparam int unsigned AxiMstIdWidth  = 2;

  typedef logic [AxiAddrWidth-1:0]   axi_addr_t;
  typedef logic [AxiDataWidth-1:0]   axi_data_t;
  typedef logic [AxiDataWidth/8-1:0] axi_strb_t;
  typedef logic [AxiSlvIdWidth-1:0]  axi_slv_id_t;
  typedef logic [AxiMstIdWidth-1:0]  axi_mst_id_t;

  typedef struct packed {
    axi_slv_id_t id;
    axi_addr_t   addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
  } axi_slv_ax_chan_t;

  typedef struct packed {
    axi_mst_id_t id;
    axi_addr_t   addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
  } axi_mst_ax_chan_t;

  typedef struct packed {
    axi_data_t data;
    axi_strb_t strb;
    logic      last;
  } axi_w_chan_t;

  typedef struct packed {
    axi_slv_id_t id;
    logic [1:0]  resp;
  } axi_slv_b_chan_t;

  typedef struct packed {
    axi_mst_id_t id;
    logic [1:0]  resp;
  } axi_mst_b_chan_t;

  typedef struct packed {
    axi_slv_id_t id;
    axi_data_t   data;
    logic [1:0]  resp;
    logic        last;
  } axi_slv_r_chan_t;

  typedef struct packed {
    axi_mst_id_t id;
    axi_data_t   data;
    logic [1:0]  resp;
    logic        last;
  } axi_mst_r_chan_t;

  typedef struct packed {
    axi_slv_ax_chan_t aw;
    logic             aw_valid;
    axi_w_chan_t      w;
    logic             w_valid;
    logic             b_ready;
    axi_slv_ax_chan_t ar;
    logic             ar_valid;
    logic             r_ready;
  } axi_slv_req_t;

  typedef struct packed {
    logic            aw_ready;
    logic            ar_ready;
    logic            w_ready;
    axi_slv_b_chan_t b;
    logic            b_valid;
    axi_slv_r_chan_t r;
    logic            r_valid;
  } axi_slv_resp_t;

  typedef struct packed {
    axi_mst_ax_chan_t aw;
    logic             aw_valid;
    axi_w_chan_t      w;
    logic             w_valid;
    logic             b_ready;
    axi_mst_ax_chan_t ar;
    logic             ar_valid;
    logic             r_ready;
  } axi_mst_req_t;

  typedef struct packed {
    logic            aw_ready;
    logic            ar_ready;
    logic            w_ready;
    axi_mst_b_chan_t b;
    logic            b_valid;
    axi_mst_r_chan_t r;
    logic            r_valid;
  } axi_mst_resp_t;

endpackage

// File: rtl/axi_id_remap_table.sv
// One remap table: maps in-flight slave IDs to compact indices and counts
// outstanding transactions per index. Index/full lookup is combinational.
module axi_id_remap_table
  import axi_id_remap_pkg::*;
#(
  parameter int unsigned IdWidth      = 4,
  parameter int unsigned MaxUniqIds   = 4,
  parameter int unsigned MaxTxnsPerId = 4,
  parameter int unsigned IdxWidth     = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [IdWidth-1:0]  push_id,
  input  logic                push_valid,
  output logic [IdxWidth-1:0] push_idx,
  output logic                push_full,
  input  logic [IdxWidth-1:0] pop_idx,
  input  logic                pop_valid,
  output logic [IdWidth-1:0]  pop_id
);

  localparam int unsigned CntWidth = $clog2(MaxTxnsPerId + 1);

  typedef logic [CntWidth-1:0] cnt_t;
  typedef logic [IdWidth-1:0]  id_t;
  typedef logic [IdxWidth-1:0] idx_t;

  localparam cnt_t CntMax = cnt_t'(MaxTxnsPerId);

  id_t  id_reg  [MaxUniqIds];
  cnt_t cnt_reg [MaxUniqIds];

  logic [MaxUniqIds-1:0] hit;
  logic [MaxUniqIds-1:0] is_free;
  logic [MaxUniqIds-1:0] push_sel;
  logic [MaxUniqIds-1:0] pop_sel;

  for (genvar gi = 0; gi < MaxUniqIds; gi++) begin : gen_entry
    assign is_free[gi]  = (cnt_reg[gi] == '0);
    assign hit[gi]      = ~is_free[gi] & (id_reg[gi] == push_id);
    assign push_sel[gi] = push_valid & ~push_full & (push_idx == idx_t'(gi));
    // A pop on a free entry is illegal; ignoring it keeps the counter from wrapping.
    assign pop_sel[gi]  = pop_valid & ~is_free[gi] & (pop_idx == idx_t'(gi));
  end

  // An ID lives in at most one entry, so a hit always wins over allocating.
  always_comb begin
    push_idx  = '0;
    push_full = 1'b1;
    if (|hit) begin
      for (int i = MaxUniqIds - 1; i >= 0; i--) begin
        if (hit[i]) push_idx = idx_t'(i);
      end
      push_full = (cnt_reg[push_idx] == CntMax);
    end else if (|is_free) begin
      for (int i = MaxUniqIds - 1; i >= 0; i--) begin
        if (is_free[i]) push_idx = idx_t'(i);
      end
      push_full = 1'b0;
    end
  end

  assign pop_id = id_reg[pop_idx];

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < MaxUniqIds; i++) begin
      if (push_sel[i]) id_reg[i] <= push_id;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < MaxUniqIds; i++) cnt_reg[i] <= '0;
    end else begin
      for (int i = 0; i < MaxUniqIds; i++) begin
        if (push_sel[i] && !pop_sel[i]) begin
          cnt_reg[i] <= cnt_reg[i] + cnt_t'(1);
        end else if (pop_sel[i] && !push_sel[i]) begin
          cnt_reg[i] <= cnt_reg[i] - cnt_t'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && pop_valid) begin
      assert (!is_free[pop_idx])
        else $error("axi_id_remap_table: response on free entry %0d", pop_idx);
    end
  end

endmodule

// File: rtl/axi_id_remap.sv
// Remaps wide slave-port AXI IDs onto a compact master-port ID space, with
// independent tables for the write (AW/B) and read (AR/R) directions.
module axi_id_remap
  import axi_id_remap_pkg::*;
#(
  parameter int unsigned AxiSlvPortIdWidth    = 4,
  parameter int unsigned AxiSlvPortMaxUniqIds = 4,
  parameter int unsigned AxiMaxTxnsPerId      = 4,
  parameter int unsigned AxiMstPortIdWidth    = 2,
  parameter type slv_req_t  = axi_slv_req_t,
  parameter type slv_resp_t = axi_slv_resp_t,
  parameter type mst_req_t  = axi_mst_req_t,
  parameter type mst_resp_t = axi_mst_resp_t
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  slv_req_t  slv_req_i,
  output slv_resp_t slv_resp_o,
  output mst_req_t  mst_req_o,
  input  mst_resp_t mst_resp_i
);

  localparam int unsigned IdxWidth =
    (AxiSlvPortMaxUniqIds > 1) ? $clog2(AxiSlvPortMaxUniqIds) : 1;

  typedef logic [IdxWidth-1:0]          idx_t;
  typedef logic [AxiSlvPortIdWidth-1:0] sid_t;

  if (AxiSlvPortMaxUniqIds < 1) begin : gen_bad_uniq
    $error("AxiSlvPortMaxUniqIds must be at least 1");
  end
  if (AxiMaxTxnsPerId < 1) begin : gen_bad_txns
    $error("AxiMaxTxnsPerId must be at least 1");
  end
  if (AxiMstPortIdWidth < $clog2(AxiSlvPortMaxUniqIds)) begin : gen_bad_mst_w
    $error("AxiMstPortIdWidth too narrow for AxiSlvPortMaxUniqIds");
  end

  idx_t aw_idx, ar_idx;
  logic aw_full, ar_full;
  sid_t b_sid, r_sid;
  logic aw_fwd, ar_fwd, aw_push, ar_push, b_pop, r_pop;

  assign aw_fwd  = slv_req_i.aw_valid & ~aw_full;
  assign ar_fwd  = slv_req_i.ar_valid & ~ar_full;
  assign aw_push = aw_fwd & mst_resp_i.aw_ready;
  assign ar_push = ar_fwd & mst_resp_i.ar_ready;
  assign b_pop   = mst_resp_i.b_valid & slv_req_i.b_ready;
  // A read transaction only retires on its final beat.
  assign r_pop   = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;

  axi_id_remap_table #(
    .IdWidth      (AxiSlvPortIdWidth),
    .MaxUniqIds   (AxiSlvPortMaxUniqIds),
    .MaxTxnsPerId (AxiMaxTxnsPerId),
    .IdxWidth     (IdxWidth)
  ) i_wr_table (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_id    (slv_req_i.aw.id),
    .push_valid (aw_push),
    .push_idx   (aw_idx),
    .push_full  (aw_full),
    .pop_idx    (idx_t'(mst_resp_i.b.id)),
    .pop_valid  (b_pop),
    .pop_id     (b_sid)
  );

  axi_id_remap_table #(
    .IdWidth      (AxiSlvPortIdWidth),
    .MaxUniqIds   (AxiSlvPortMaxUniqIds),
    .MaxTxnsPerId (AxiMaxTxnsPerId),
    .IdxWidth     (IdxWidth)
  ) i_rd_table (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_id    (slv_req_i.ar.id),
    .push_valid (ar_push),
    .push_idx   (ar_idx),
    .push_full  (ar_full),
    .pop_idx    (idx_t'(mst_resp_i.r.id)),
    .pop_valid  (r_pop),
    .pop_id     (r_sid)
  );

  always_comb begin
    mst_req_o          = '0;
    mst_req_o.aw.id    = AxiMstPortIdWidth'(aw_idx);
    mst_req_o.aw.addr  = slv_req_i.aw.addr;
    mst_req_o.aw.len   = slv_req_i.aw.len;
    mst_req_o.aw.size  = slv_req_i.aw.size;
    mst_req_o.aw.burst = slv_req_i.aw.burst;
    mst_req_o.aw.lock  = slv_req_i.aw.lock;
    mst_req_o.aw.cache = slv_req_i.aw.cache;
    mst_req_o.aw.prot  = slv_req_i.aw.prot;
    mst_req_o.aw.qos   = slv_req_i.aw.qos;
    mst_req_o.aw_valid = aw_fwd;
    mst_req_o.w        = slv_req_i.w;
    mst_req_o.w_valid  = slv_req_i.w_valid;
    mst_req_o.b_ready  = slv_req_i.b_ready;
    mst_req_o.ar.id    = AxiMstPortIdWidth'(ar_idx);
    mst_req_o.ar.addr  = slv_req_i.ar.addr;
    mst_req_o.ar.len   = slv_req_i.ar.len;
    mst_req_o.ar.size  = slv_req_i.ar.size;
    mst_req_o.ar.burst = slv_req_i.ar.burst;
    mst_req_o.ar.lock  = slv_req_i.ar.lock;
    mst_req_o.ar.cache = slv_req_i.ar.cache;
    mst_req_o.ar.prot  = slv_req_i.ar.prot;
    mst_req_o.ar.qos   = slv_req_i.ar.qos;
    mst_req_o.ar_valid = ar_fwd;
    mst_req_o.r_ready  = slv_req_i.r_ready;
  end

  always_comb begin
    slv_resp_o          = '0;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & ~aw_full;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & ~ar_full;
    slv_resp_o.w_ready  = mst_resp_i.w_ready;
    slv_resp_o.b.id     = b_sid;
    slv_resp_o.b.resp   = mst_resp_i.b.resp;
    slv_resp_o.b_valid  = mst_resp_i.b_valid;
    slv_resp_o.r.id     = r_sid;
    slv_resp_o.r.data   = mst_resp_i.r.data;
    slv_resp_o.r.resp   = mst_resp_i.r.resp;
    slv_resp_o.r.last   = mst_resp_i.r.last;
    slv_resp_o.r_valid  = mst_resp_i.r_valid;
  end

endmodule

// File: tb/tb_axi_id_remap.sv
// Directed bench for axi_id_remap: each task drives one scenario and checks
// the combinational outputs at the falling edge against hand-computed values.
module tb_axi_id_remap;
  import axi_id_remap_pkg::*;

  logic clk = 1'b0;
  logic rst;
  axi_slv_req_t  slv_req;
  axi_slv_resp_t slv_resp;
  axi_mst_req_t  mst_req;
  axi_mst_resp_t mst_resp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axi_id_remap #(
    .AxiSlvPortIdWidth    (4),
    .AxiSlvPortMaxUniqIds (4),
    .AxiMaxTxnsPerId      (4),
    .AxiMstPortIdWidth    (2),
    .slv_req_t            (axi_slv_req_t),
    .slv_resp_t           (axi_slv_resp_t),
    .mst_req_t            (axi_mst_req_t),
    .mst_resp_t           (axi_mst_resp_t)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .slv_req_i  (slv_req),
    .slv_resp_o (slv_resp),
    .mst_req_o  (mst_req),
    .mst_resp_i (mst_resp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    slv_req.aw_valid  = 1'b0;
    slv_req.ar_valid  = 1'b0;
    slv_req.w_valid   = 1'b0;
    mst_resp.b_valid  = 1'b0;
    mst_resp.r_valid  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_aw(input logic [3:0] id);
    slv_req.aw_valid = 1'b1;
    slv_req.aw.id    = id;
    slv_req.aw.addr  = {24'h0, id, 4'h0};
  endtask

  task automatic set_ar(input logic [3:0] id);
    slv_req.ar_valid = 1'b1;
    slv_req.ar.id    = id;
    slv_req.ar.addr  = {24'h1, id, 4'h0};
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++; if (slv_resp.aw_ready !== 1'b1) begin bad++; $display("FAIL reset_aw_ready: got %0b want 1", slv_resp.aw_ready); end
    total++; if (slv_resp.ar_ready !== 1'b1) begin bad++; $display("FAIL reset_ar_ready: got %0b want 1", slv_resp.ar_ready); end
    total++; if (mst_req.aw_valid !== 1'b0) begin bad++; $display("FAIL reset_aw_valid: got %0b want 0", mst_req.aw_valid); end
    total++; if (mst_req.ar_valid !== 1'b0) begin bad++; $display("FAIL reset_ar_valid: got %0b want 0", mst_req.ar_valid); end
    $display("reset: idle outputs checked");
    tick();
  endtask

  task automatic test_single_write();
    do_reset();
    set_aw(4'hA);
    slv_req.aw.len  = 8'd3;
    slv_req.w_valid = 1'b1;
    slv_req.w.data  = 32'hDEADBEEF;
    slv_req.w.last  = 1'b1;
    @(negedge clk);
    total++; if (mst_req.aw_valid !== 1'b1) begin bad++; $display("FAIL sw_aw_valid: got %0b want 1", mst_req.aw_valid); end
    total++; if (mst_req.aw.id !== 2'd0) begin bad++; $display("FAIL sw_aw_id: got %0d want 0", mst_req.aw.id); end
    total++; if (mst_req.aw.addr !== 32'h0000_00A0) begin bad++; $display("FAIL sw_aw_addr: got %h want 000000a0", mst_req.aw.addr); end
    total++; if (mst_req.aw.len !== 8'd3) begin bad++; $display("FAIL sw_aw_len: got %0d want 3", mst_req.aw.len); end
    total++; if (mst_req.w.data !== 32'hDEADBEEF || mst_req.w_valid !== 1'b1) begin bad++; $display("FAIL sw_w_pass: got %h/%0b want deadbeef/1", mst_req.w.data, mst_req.w_valid); end
    total++; if (slv_resp.w_ready !== 1'b1) begin bad++; $display("FAIL sw_w_ready: got %0b want 1", slv_resp.w_ready); end
    $display("single_write: AW id A -> mst id %0d", mst_req.aw.id);
    tick();
    idle();
    mst_resp.b_valid = 1'b1;
    mst_resp.b.id    = 2'd0;
    mst_resp.b.resp  = 2'b01;
    @(negedge clk);
    total++; if (slv_resp.b.id !== 4'hA) begin bad++; $display("FAIL sw_b_id: got %h want a", slv_resp.b.id); end
    total++; if (slv_resp.b_valid !== 1'b1 || slv_resp.b.resp !== 2'b01) begin bad++; $display("FAIL sw_b_pass: got %0b/%0d want 1/1", slv_resp.b_valid, slv_resp.b.resp); end
    $display("single_write: B mst id 0 -> slv id %h", slv_resp.b.id);
    tick();
    idle();
    set_aw(4'h5);
    @(negedge clk);
    total++; if (mst_req.aw.id !== 2'd0 || mst_req.aw_valid !== 1'b1) begin bad++; $display("FAIL sw_table_empty: got id %0d valid %0b want 0/1", mst_req.aw.id, mst_req.aw_valid); end
    $display("single_write: follow-up AW id 5 -> mst id %0d", mst_req.aw.id);
    tick();
    idle();
  endtask

  task automatic test_same_id_stall();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_ar(4'h3);
      @(negedge clk);
      total++; if (mst_req.ar_valid !== 1'b1 || mst_req.ar.id !== 2'd0) begin bad++; $display("FAIL same_ar k=%0d: got valid %0b id %0d want 1/0", k, mst_req.ar_valid, mst_req.ar.id); end
      $display("same_id: AR %0d id 3 -> mst id %0d", k, mst_req.ar.id);
      tick();
    end
    @(negedge clk);
    total++; if (mst_req.ar_valid !== 1'b0 || slv_resp.ar_ready !== 1'b0) begin bad++; $display("FAIL same_stall: got valid %0b ready %0b want 0/0", mst_req.ar_valid, slv_resp.ar_ready); end
    tick();
    mst_resp.r_valid = 1'b1;
    mst_resp.r.id    = 2'd0;
    mst_resp.r.last  = 1'b0;
    @(negedge clk);
    total++; if (mst_req.ar_valid !== 1'b0) begin bad++; $display("FAIL same_stall_beat: got valid %0b want 0", mst_req.ar_valid); end
    total++; if (slv_resp.r.id !== 4'h3) begin bad++; $display("FAIL same_r_id: got %h want 3", slv_resp.r.id); end
    tick();
    mst_resp.r.last = 1'b1;
    @(negedge clk);
    total++; if (mst_req.ar_valid !== 1'b0) begin bad++; $display("FAIL same_stall_last: got valid %0b want 0", mst_req.ar_valid); end
    tick();
    mst_resp.r_valid = 1'b0;
    @(negedge clk);
    total++; if (mst_req.ar_valid !== 1'b1 || mst_req.ar.id !== 2'd0 || slv_resp.ar_ready !== 1'b1) begin bad++; $display("FAIL same_release: got valid %0b id %0d ready %0b want 1/0/1", mst_req.ar_valid, mst_req.ar.id, slv_resp.ar_ready); end
    $display("same_id: fifth AR released with mst id %0d", mst_req.ar.id);
    tick();
    idle();
  endtask

  task automatic test_unknown_id_stall();
    logic [3:0] ids [5];
    logic [1:0] exp [5];
    ids = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h2};
    exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_ar(ids[k]);
      @(negedge clk);
      total++; if (mst_req.ar_valid !== 1'b1 || mst_req.ar.id !== exp[k]) begin bad++; $display("FAIL uniq_ar k=%0d: got valid %0b id %0d want 1/%0d", k, mst_req.ar_valid, mst_req.ar.id, exp[k]); end
      $display("unknown_id: AR id %h -> mst id %0d", ids[k], mst_req.ar.id);
      tick();
    end
    set_ar(4'h5);
    mst_resp.r_valid = 1'b1;
    mst_resp.r.id    = 2'd1;
    mst_resp.r.last  = 1'b1;
    @(negedge clk);
    total++; if (mst_req.ar_valid !== 1'b0) begin bad++; $display("FAIL uniq_stall_full: got valid %0b want 0", mst_req.ar_valid); end
    total++; if (slv_resp.r.id !== 4'h2) begin bad++; $display("FAIL uniq_r_id: got %h want 2", slv_resp.r.id); end
    tick();
    @(negedge clk);
    total++; if (mst_req.ar_valid !== 1'b0) begin bad++; $display("FAIL uniq_stall_one_left: got valid %0b want 0", mst_req.ar_valid); end
    tick();
    mst_resp.r_valid = 1'b0;
    @(negedge clk);
    total++; if (mst_req.ar_valid !== 1'b1 || mst_req.ar.id !== 2'd1) begin bad++; $display("FAIL uniq_realloc: got valid %0b id %0d want 1/1", mst_req.ar_valid, mst_req.ar.id); end
    $display("unknown_id: AR id 5 -> mst id %0d", mst_req.ar.id);
    tick();
    idle();
  endtask

  task automatic test_r_burst();
    logic [3:0] ids [6];
    logic [1:0] exp [6];
    ids = '{4'h1, 4'h2, 4'h7, 4'h7, 4'h7, 4'h7};
    exp = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      set_ar(ids[k]);
      @(negedge clk);
      total++; if (mst_req.ar.id !== exp[k]) begin bad++; $display("FAIL burst_setup k=%0d: got %0d want %0d", k, mst_req.ar.id, exp[k]); end
      tick();
    end
    set_ar(4'h7);
    for (int j = 0; j < 4; j++) begin
      mst_resp.r_valid = 1'b1;
      mst_resp.r.id    = 2'd2;
      mst_resp.r.data  = 32'h100 + j;
      mst_resp.r.last  = (j == 3);
      @(negedge clk);
      total++; if (slv_resp.r.id !== 4'h7) begin bad++; $display("FAIL burst_r_id beat=%0d: got %h want 7", j, slv_resp.r.id); end
      total++; if (slv_resp.r.data !== 32'h100 + j || slv_resp.r.last !== (j == 3)) begin bad++; $display("FAIL burst_r_pass beat=%0d: got %h/%0b", j, slv_resp.r.data, slv_resp.r.last); end
      total++; if (mst_req.ar_valid !== 1'b0) begin bad++; $display("FAIL burst_stall beat=%0d: got valid %0b want 0", j, mst_req.ar_valid); end
      $display("r_burst: beat %0d returned id %h", j, slv_resp.r.id);
      tick();
    end
    mst_resp.r_valid = 1'b0;
    @(negedge clk);
    total++; if (mst_req.ar_valid !== 1'b1 || mst_req.ar.id !== 2'd2) begin bad++; $display("FAIL burst_release: got valid %0b id %0d want 1/2", mst_req.ar_valid, mst_req.ar.id); end
    tick();
    idle();
  endtask

  task automatic test_push_pop_same_cycle();
    do_reset();
    set_aw(4'hA);
    @(negedge clk);
    total++; if (mst_req.aw.id !== 2'd0) begin bad++; $display("FAIL pp_first: got %0d want 0", mst_req.aw.id); end
    tick();
    mst_resp.b_valid = 1'b1;
    mst_resp.b.id    = 2'd0;
    @(negedge clk);
    total++; if (mst_req.aw_valid !== 1'b1 || mst_req.aw.id !== 2'd0 || slv_resp.aw_ready !== 1'b1) begin bad++; $display("FAIL pp_not_stalled: got valid %0b id %0d ready %0b want 1/0/1", mst_req.aw_valid, mst_req.aw.id, slv_resp.aw_ready); end
    total++; if (slv_resp.b.id !== 4'hA) begin bad++; $display("FAIL pp_b_id: got %h want a", slv_resp.b.id); end
    $display("push_pop: AW and B on entry 0 in one cycle");
    tick();
    mst_resp.b_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (mst_req.aw_valid !== 1'b1 || mst_req.aw.id !== 2'd0) begin bad++; $display("FAIL pp_fill k=%0d: got valid %0b id %0d want 1/0", k, mst_req.aw_valid, mst_req.aw.id); end
      tick();
    end
    @(negedge clk);
    total++; if (mst_req.aw_valid !== 1'b0) begin bad++; $display("FAIL pp_count: got valid %0b want 0 (entry 0 at 4)", mst_req.aw_valid); end
    tick();
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_aw(4'(k + 1));
      @(negedge clk);
      total++; if (mst_req.aw.id !== 2'(k)) begin bad++; $display("FAIL rm_setup k=%0d: got %0d want %0d", k, mst_req.aw.id, k); end
      tick();
    end
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_aw(4'h7);
    @(negedge clk);
    total++; if (mst_req.aw_valid !== 1'b1 || mst_req.aw.id !== 2'd0) begin bad++; $display("FAIL rm_after: got valid %0b id %0d want 1/0", mst_req.aw_valid, mst_req.aw.id); end
    $display("reset_mid: AW id 7 -> mst id %0d", mst_req.aw.id);
    tick();
    set_aw(4'h8);
    @(negedge clk);
    total++; if (mst_req.aw.id !== 2'd1) begin bad++; $display("FAIL rm_next: got %0d want 1", mst_req.aw.id); end
    tick();
    idle();
  endtask

  initial begin
    rst      = 1'b1;
    slv_req  = '0;
    mst_resp = '0;
    mst_resp.aw_ready = 1'b1;
    mst_resp.ar_ready = 1'b1;
    mst_resp.w_ready  = 1'b1;
    slv_req.b_ready   = 1'b1;
    slv_req.r_ready   = 1'b1;
    test_reset();
    test_single_write();
    test_same_id_stall();
    test_unknown_id_stall();
    test_r_burst();
    test_push_pop_same_cycle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_id_remap.md
AXI_ID_REMAP -- requirements
Module: axi_id_remap

Interface
REQ-001 SHALL have parameter AxiSlvPortIdWidth, default 4: slave-port ID width.
REQ-002 SHALL have parameter AxiSlvPortMaxUniqIds, default 4: distinct slave IDs in flight per direction, at least 1.
REQ-003 SHALL have parameter AxiMaxTxnsPerId, default 4: outstanding transactions per unique ID, at least 1.
REQ-004 SHALL have parameter AxiMstPortIdWidth, default 2: master-port ID width, at least clog2(AxiSlvPortMaxUniqIds).
REQ-005 SHALL have type parameters slv_req_t, slv_resp_t, mst_req_t, mst_resp_t: AXI4 request/response structs of the two ports.
REQ-006 SHALL have one clock and a synchronous, active-high reset, named per codebase: clk_i  in  1  clock.
REQ-007 rst_i  in  1  synchronous active-high reset.
REQ-008 slv_req_i  in  slv_req_t  upstream request.
REQ-009 slv_resp_o  out  slv_resp_t  upstream response.
REQ-010 mst_req_o  out  mst_req_t  downstream request, remapped IDs.
REQ-011 mst_resp_i  in  mst_resp_t  downstream response.

Function
REQ-012 SHALL keep two independent remap tables, write (AW/B) and read (AR/R), each with AxiSlvPortMaxUniqIds entries; entry = {slave ID, counter 0..AxiMaxTxnsPerId}; entry free when counter==0.
REQ-013 Master ID SHALL be the table index, zero-extended to AxiMstPortIdWidth; all other AW/AR/W fields pass unchanged, combinationally.
REQ-014 AW/AR with slave ID already in table and counter<AxiMaxTxnsPerId SHALL use that index.
REQ-015 AW/AR with unknown ID SHALL allocate the lowest-index free entry.
REQ-016 AW/AR SHALL stall (mst valid=0, slv ready=0) when the matching entry's counter==AxiMaxTxnsPerId, or when the ID is unknown and no entry is free; it SHALL never take a second entry for an ID already present.
REQ-017 Forwarding when not stalled SHALL be combinational (0 latency); slv ready = mst ready.
REQ-018 Table update SHALL happen only on the master-side handshake: counter+1 and store ID.
REQ-019 B SHALL return the stored slave ID of entry[b.id]; on B handshake counter-1.
REQ-020 R SHALL return the stored slave ID of entry[r.id]; counter-1 only on an R handshake with last=1.
REQ-021 Simultaneous push and pop on the same entry in one cycle SHALL leave its counter unchanged; push and pop on different entries both apply.
REQ-022 An entry whose counter reaches 0 SHALL be reusable for any ID from the next cycle.
REQ-023 W, B and R valid/ready and payloads other than the ID SHALL pass unmodified.
REQ-024 A B/R response whose ID indexes a free entry is illegal; a simulation assertion SHALL flag it, and the counter SHALL not wrap.

Reset
REQ-025 While rst_i=1 at a clk_i edge, all counters SHALL go to 0 and all entries become free; stored IDs are don't-care.
REQ-026 Outputs are combinational pass-through and SHALL carry no registered reset value; the upstream and downstream blocks hold valid low during reset.
REQ-027 A reset mid-transaction SHALL drop all outstanding bookkeeping without any response.

Structure
REQ-028 Only the struct types SHALL come from the shared AXI typedef package/macros; the block needs no new package constants.
REQ-029 One sub-module, axi_id_remap_table, SHALL be instantiated twice (write, read), with ports: push {id, valid} -> index/full, pop {index, valid} -> stored id.
REQ-030 Parameter legality SHALL be checked with elaboration-time assertions.

Verification
REQ-031 Single write, ID 0xA: AW master id 0, B id 0 returned as 0xA; table empty afterwards.
REQ-032 Four ARs with ID 0x3: all carry master id 0; a fifth AR stalls until one R with last=1 completes, then goes out with id 0.
REQ-033 ARs with IDs 0x1, 0x2, 0x3, 0x4: master ids 0,1,2,3; AR with ID 0x5 stalls until all R bursts for 0x2 complete, then takes id 1.
REQ-034 R burst len 3 on id 2: counter decrements only at beat 4; all beats return the original ID.
REQ-035 B for entry 0 and a new AW with ID 0xA in the same cycle: entry 0 counter unchanged and the AW is not stalled.
REQ-036 Reset asserted with 3 writes outstanding: after reset, AW ID 0x7 gets master id 0.
